// File: rtl/sevseg_scan.sv
// sevseg_scan: 8-slot multiplexed seven-segment driver for a signed 4-digit BCD temperature with C/F unit letter.
// Leading-zero blanking is compiled in when SEVSEG_LZB_EN is defined.
module sevseg_scan #(
   parameter int DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] thou,
   input  logic [3:0] hund,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic       sign,
   input  logic       c_f,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       frame
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] cnt;
   logic [2:0] idx, minus_slot;
   logic [17:0] pend, disp, in_vec;
   logic [3:0] d_thou, d_hund, d_tens, d_ones;
   logic d_sign, d_cf, lp, wrap, commit, nz, sh_t, sh_h, sh_d;
   logic [6:0] nxt_seg;
   function automatic logic [6:0] bcd7(input logic [3:0] d);
      case (d)
         4'd0: bcd7 = 7'h40;
         4'd1: bcd7 = 7'h79;
         4'd2: bcd7 = 7'h24;
         4'd3: bcd7 = 7'h30;
         4'd4: bcd7 = 7'h19;
         4'd5: bcd7 = 7'h12;
         4'd6: bcd7 = 7'h02;
         4'd7: bcd7 = 7'h78;
         4'd8: bcd7 = 7'h00;
         4'd9: bcd7 = 7'h10;
         default: bcd7 = 7'h06;
      endcase
   endfunction
   assign in_vec = {thou, hund, tens, ones, sign, c_f};
   assign {d_thou, d_hund, d_tens, d_ones, d_sign, d_cf} = disp;
   assign wrap = cnt == CW'(DIV - 1);
   assign commit = wrap && idx == 3'd7;
   assign nz = |{d_thou, d_hund, d_tens, d_ones};
`ifdef SEVSEG_LZB_EN
   assign sh_t = d_thou != 4'd0;
   assign sh_h = sh_t || d_hund != 4'd0;
   assign sh_d = sh_h || d_tens != 4'd0;
   // minus sits just left of the most significant digit still shown
   assign minus_slot = sh_t ? 3'd5 : sh_h ? 3'd4 : sh_d ? 3'd3 : 3'd2;
`else
   assign sh_t = 1'b1;
   assign sh_h = 1'b1;
   assign sh_d = 1'b1;
   assign minus_slot = 3'd5;
`endif
   always_comb begin
      nxt_seg = 7'h7F;
      case (idx)
         3'd0: nxt_seg = d_cf ? 7'h0E : 7'h46;
         3'd1: nxt_seg = bcd7(d_ones);
         3'd2: nxt_seg = sh_d ? bcd7(d_tens) : 7'h7F;
         3'd3: nxt_seg = sh_h ? bcd7(d_hund) : 7'h7F;
         3'd4: nxt_seg = sh_t ? bcd7(d_thou) : 7'h7F;
         default: nxt_seg = 7'h7F;
      endcase
      if (d_sign && nz && idx == minus_slot) nxt_seg = 7'h3F;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         pend  <= '0;
         disp  <= '0;
         lp    <= 1'b0;
         an    <= 8'hFF;
         seg   <= 7'h7F;
         frame <= 1'b0;
      end else begin
         cnt   <= wrap ? '0 : cnt + CW'(1);
         if (wrap) idx <= idx + 3'd1;
         frame <= commit;
         an    <= ~(8'd1 << idx);
         seg   <= nxt_seg;
         if (load) pend <= in_vec;
         // a load landing on the commit edge goes straight to the display
         if (commit && (load || lp)) disp <= load ? in_vec : pend;
         lp    <= commit ? 1'b0 : (lp || load);
      end
   end
endmodule

// File: tb/tb_sevseg_scan.sv
// tb_sevseg_scan: directed checks of scan order, digit/sign/unit encoding, load/commit timing and reset.
module tb_sevseg_scan;
   localparam int DIV = 4;
`ifdef SEVSEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, load = 1'b0, sign = 1'b0, c_f = 1'b0;
   logic [3:0] thou = 4'd0, hund = 4'd0, tens = 4'd0, ones = 4'd0;
   logic [7:0] an;
   logic [6:0] seg;
   logic frame;
   int chk_cnt = 0, pass_cnt = 0;

   always #5 clk = ~clk;

   sevseg_scan #(.DIV(DIV)) dut (
      .clk(clk), .rst(rst), .load(load), .thou(thou), .hund(hund), .tens(tens), .ones(ones),
      .sign(sign), .c_f(c_f), .an(an), .seg(seg), .frame(frame)
   );

   task automatic do_load(input logic [3:0] t, h, d, o, input logic s, f);
      thou = t; hund = h; tens = d; ones = o; sign = s; c_f = f; load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   // wait for a frame pulse, then record the segment pattern of each slot over the following frame
   task automatic grab(output logic [55:0] got, output logic bad);
      logic [7:0] seen;
      int k;
      bit found;
      got = '1; seen = '0; bad = 1'b0; found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk); #1;
         found = frame;
      end
      if (!found) bad = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk); #1;
         if (frame !== (i == 32)) bad = 1'b1;
         k = -1;
         for (int j = 0; j < 8; j++) if (an === ~(8'd1 << j)) k = j;
         if (k < 0) bad = 1'b1;
         else if (!seen[k]) begin
            seen[k] = 1'b1;
            got[k*7 +: 7] = seg;
         end else if (got[k*7 +: 7] !== seg) bad = 1'b1;
      end
      if (seen !== 8'hFF) bad = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if (an !== 8'hFF) $display("FAIL reset_an got %h want ff", an); else pass_cnt++;
      chk_cnt++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", seg); else pass_cnt++;
      chk_cnt++; if (frame !== 1'b0) $display("FAIL reset_frame got %b want 0", frame); else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_cnt++; if (an !== 8'hFE) $display("FAIL release_an got %h want fe", an); else pass_cnt++;
      chk_cnt++; if (seg !== 7'h46) $display("FAIL release_seg got %h want 46", seg); else pass_cnt++;
   endtask

   task automatic test_patterns;
      logic [55:0] got, exp;
      logic bad;
      for (int t = 0; t < 7; t++) begin
         case (t)
            0: begin do_load(0, 0, 5, 0, 0, 0);
               exp = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h46}
                         : {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h12, 7'h40, 7'h46}; end
            1: begin do_load(0, 0, 4, 0, 1, 1);
               exp = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h40, 7'h0E}
                         : {7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40, 7'h19, 7'h40, 7'h0E}; end
            2: begin do_load(0, 0, 0, 0, 1, 0);
               exp = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h46}
                         : {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h46}; end
            3: begin do_load(0, 0, 1, 0, 1, 0);
               exp = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h79, 7'h40, 7'h46}
                         : {7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40, 7'h79, 7'h40, 7'h46}; end
            4: begin do_load(4'hA, 0, 9, 8, 1, 1);
               exp = {7'h7F, 7'h7F, 7'h3F, 7'h06, 7'h40, 7'h10, 7'h00, 7'h0E}; end
            5: begin do_load(7, 6, 3, 2, 0, 0);
               exp = {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h02, 7'h30, 7'h24, 7'h46}; end
            default: begin do_load(0, 1, 0, 0, 1, 0);
               exp = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h79, 7'h40, 7'h40, 7'h46}
                         : {7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h79, 7'h40, 7'h40, 7'h46}; end
         endcase
         grab(got, bad);
         chk_cnt++; if (bad !== 1'b0) $display("FAIL pat%0d_scan got bad=%b want 0", t, bad); else pass_cnt++;
         for (int k = 0; k < 8; k++) begin
            chk_cnt++;
            if (got[k*7 +: 7] !== exp[k*7 +: 7])
               $display("FAIL pat%0d_slot%0d got %h want %h", t, k, got[k*7 +: 7], exp[k*7 +: 7]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_abort;
      logic [55:0] got, exp;
      logic bad;
      do_load(9, 9, 9, 9, 1, 1);
      repeat (3) @(posedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++; if (an !== 8'hFF) $display("FAIL abort_an got %h want ff", an); else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_cnt++; if (seg !== 7'h46) $display("FAIL abort_release_seg got %h want 46", seg); else pass_cnt++;
      exp = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h46}
                : {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h46};
      grab(got, bad);
      chk_cnt++; if (bad !== 1'b0) $display("FAIL abort_scan got bad=%b want 0", bad); else pass_cnt++;
      chk_cnt++; if (got !== exp) $display("FAIL abort_frame got %h want %h", got, exp); else pass_cnt++;
   endtask

   task automatic test_latest_wins;
      logic [55:0] got;
      logic bad, seen50;
      seen50 = 1'b0;
      grab(got, bad);
      chk_cnt++; if (bad !== 1'b0) $display("FAIL sync_scan got bad=%b want 0", bad); else pass_cnt++;
      do_load(0, 0, 5, 0, 0, 0);
      repeat (5) begin
         @(posedge clk); #1;
         if (an === 8'hFB && seg === 7'h12) seen50 = 1'b1;
      end
      do_load(0, 0, 3, 0, 0, 0);
      grab(got, bad);
      chk_cnt++; if (bad !== 1'b0) $display("FAIL latest_scan got bad=%b want 0", bad); else pass_cnt++;
      chk_cnt++; if (got[20:14] !== 7'h30) $display("FAIL latest_slot2 got %h want 30", got[20:14]); else pass_cnt++;
      chk_cnt++; if (got[13:7] !== 7'h40) $display("FAIL latest_slot1 got %h want 40", got[13:7]); else pass_cnt++;
      chk_cnt++; if (seen50 !== 1'b0) $display("FAIL latest_no50 got %b want 0", seen50); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_patterns;
      test_reset_abort;
      test_latest_wins;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/sevseg_scan.md
SEVSEG_SCAN -- requirements
Module: sevseg_scan

Interface
REQ-001 SHALL have parameter DIV, default 100000, giving clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port load  in  1  one-cycle strobe capturing thou/hund/tens/ones/sign/c_f into the pending register.
REQ-005 SHALL have ports thou, hund, tens, ones  in  4 each  BCD digits from the temperature display stage.
REQ-006 SHALL have port sign  in  1  1 = negative value.
REQ-007 SHALL have port c_f  in  1  unit select: 0 = Celsius, 1 = Fahrenheit.
REQ-008 SHALL have port an  out  8  digit anodes, active-low, one-hot; an[0] is the rightmost digit.
REQ-009 SHALL have port seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port frame  out  1  one-cycle pulse when the scan wraps from slot 7 to slot 0.

Function
REQ-011 SHALL keep prescaler cnt, counting 0..DIV-1; on DIV-1 it SHALL wrap to 0 and advance slot index idx, where 7 wraps to 0.
REQ-012 SHALL register an and seg from idx and the display registers, so outputs lag idx by one clock.
REQ-013 SHALL drive an = ~(1 << idx) exactly; no two anodes are ever low together.
REQ-014 SHALL assign slots as: 0 = unit letter, 1 = ones, 2 = tens, 3 = hund, 4 = thou, 5-7 = sign or blank (see REQ-019/REQ-024).
REQ-015 SHALL use these seg codes: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex); BCD 10-15 = 06 ('E'); 'C'=46; 'F'=0E; minus=3F; blank=7F.
REQ-016 SHALL set load to write the pending register; a second load before commit overwrites it, so the latest capture wins.
REQ-017 SHALL copy pending to the display registers in the same cycle frame pulses, and only if a load occurred since the last commit, so values never change mid-frame.
REQ-018 SHALL handle load coincident with a commit edge by committing the value being loaded in that cycle.
REQ-019 SHALL, when the displayed value has sign=1 and at least one digit nonzero, drive minus in the slot immediately left of the most significant shown digit.
REQ-020 SHALL suppress minus when all four digits are zero; "-0" is never shown.
REQ-021 SHALL drive blank (7F) in slots 6 and 7 and in any slot not otherwise used.
REQ-022 SHALL pulse frame high for exactly one cycle, the cycle in which idx changes from 7 to 0.

Reset
REQ-023 SHALL, with rst high, clear cnt, idx, pending, the display registers and the load-pending flag to 0, and drive an=FF, seg=7F and frame=0 on the next edge. The first cycle after rst falls SHALL show an=FE, seg=46; rst mid-frame SHALL abort the scan and discard any uncommitted load.

Configuration
REQ-024 SHALL compile leading-zero blanking in or out with macro SEVSEG_LZB_EN:
- Defined: thou blank if 0; hund blank if thou and hund are 0; tens blank if thou, hund and tens are 0; ones never blank. Minus per REQ-019.
- Undefined: all four digits are always shown, and minus, when shown, is fixed at slot 5.

Verification (DIV=4, SEVSEG_LZB_EN defined unless noted)
REQ-025 SHALL cover: rst high 3 cycles -> an=FF, seg=7F, frame=0; after release an=FE, seg=46.
REQ-026 SHALL cover: load 0,0,5,0, sign=0, c_f=0, then the next frame -> slot1=40, slot2=12, slots3-7=7F, slot0=46.
REQ-027 SHALL cover: load 0,0,4,0, sign=1, c_f=1 -> slot0=0E, slot2=19, slot3=3F, slot4=7F.
REQ-028 SHALL cover: load 0,0,0,0, sign=1 -> slot1=40, slots2-7=7F, no minus.
REQ-029 SHALL cover: load 50 then load 30 within one frame -> next frame shows 30; 50 never appears; displayed digits are constant within every frame.
REQ-030 SHALL cover, with SEVSEG_LZB_EN undefined: load 0,0,1,0, sign=1 -> slot4=40, slot3=40, slot2=79, slot5=3F.
